// File: rtl/q5_pkg.sv
// Shared types and defaults for the q5 serial pattern detector.
package q5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam int         DEF_WIDTH   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  // Counter helper: holds at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/q5_shift_reg.sv
// WIDTH-bit serial-in shift register with enable and synchronous reset.
// Newest bit enters at the LSB; shreg_nxt is the value loaded on the next edge.
module q5_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] shreg,
  output logic [WIDTH-1:0] shreg_nxt
);

  always_comb begin
    shreg_nxt = shreg;
    if (en) shreg_nxt = {shreg[WIDTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (r) shreg <= '0;
    else   shreg <= shreg_nxt;
  end

endmodule

// File: rtl/q5_seq_detector.sv
// Overlapping serial pattern detector with saturating match counter and a
// one-deep valid/ready event output. Define Q5_PARITY_EN to add parity outputs.
//
// state | meaning
// IDLE  | no bits accepted since reset
// FILL  | fewer than WIDTH bits accepted, matches suppressed
// SCAN  | shift register full, every accepted bit is compared
module q5_seq_detector import q5_pkg::*; #(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             din_valid,
  input  logic             din,
  output logic [WIDTH-1:0] shreg,
  output logic             filled,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic             lost
`ifdef Q5_PARITY_EN
  ,
  output logic             parity,
  output logic             parity_ok
`endif
);

  localparam int               FC_W      = $clog2(WIDTH + 1);
  localparam logic [FC_W-1:0]  FILL_FULL = FC_W'(WIDTH);
  localparam logic [31:0]      CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           state, state_nxt;
  logic [FC_W-1:0]  fill_cnt;
  logic [WIDTH-1:0] shreg_nxt;
  logic             match;

  q5_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk       (clk),
    .r         (r),
    .en        (din_valid),
    .din       (din),
    .shreg     (shreg),
    .shreg_nxt (shreg_nxt)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (din_valid && fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (din_valid) state_nxt = FILL;
      FILL:    if (din_valid && fill_cnt == FILL_FULL - 1'b1) state_nxt = SCAN;
      SCAN:    state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  // Match is judged on the value being shifted in, so the flag registers on
  // the same edge that accepts the completing bit.
  always_comb begin
    filled = (state == SCAN);
    match  = din_valid && (state_nxt == SCAN) && (shreg_nxt == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      evt_valid <= 1'b0;
      match_cnt <= '0;
      lost      <= 1'b0;
    end else if (match) begin
      evt_valid <= 1'b1;
      match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_MAX));
      if (evt_valid && !evt_ready) lost <= 1'b1;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

`ifdef Q5_PARITY_EN
  always_ff @(posedge clk) begin
    if (r) begin
      parity    <= 1'b0;
      parity_ok <= 1'b0;
    end else begin
      parity <= ^shreg_nxt;
      if (match) parity_ok <= ~^shreg_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_q5_seq_detector.sv
// Scoreboard bench for q5_seq_detector: a bit-history model pushes expected
// outputs per driven cycle, popped and compared after each clock edge.
module tb_q5_seq_detector;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       evt_ready = 1'b0;

  logic [3:0] shreg, shreg_s;
  logic       filled, filled_s;
  logic       evt_valid, evt_valid_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;
  logic       lost, lost_s;
`ifdef Q5_PARITY_EN
  logic       parity, parity_ok, parity_s, parity_ok_s;
`endif

  always #5 clk = ~clk;

  q5_seq_detector u_dut (
    .clk       (clk),
    .r         (r),
    .din_valid (din_valid),
    .din       (din),
    .shreg     (shreg),
    .filled    (filled),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .match_cnt (match_cnt),
    .lost      (lost)
`ifdef Q5_PARITY_EN
    ,
    .parity    (parity),
    .parity_ok (parity_ok)
`endif
  );

  q5_seq_detector #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .r         (r),
    .din_valid (din_valid),
    .din       (din),
    .shreg     (shreg_s),
    .filled    (filled_s),
    .evt_valid (evt_valid_s),
    .evt_ready (evt_ready),
    .match_cnt (match_cnt_s),
    .lost      (lost_s)
`ifdef Q5_PARITY_EN
    ,
    .parity    (parity_s),
    .parity_ok (parity_ok_s)
`endif
  );

  typedef struct {
    logic [3:0] shreg;
    logic       filled;
    logic       valid;
    logic       lost;
    logic [7:0] mcnt;
    logic [1:0] mcnt2;
    logic       pok;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // model state: bit history and handshake
  logic [3:0] m_hist;
  int         m_bits;
  logic       m_valid, m_lost, m_pok;
  int         m_mcnt, m_mcnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic dv, input logic d, input logic rdy, input logic rst);
    exp_t e;
    logic hit;
    @(negedge clk);
    din_valid = dv;
    din       = d;
    evt_ready = rdy;
    r         = rst;
    if (rst) begin
      m_hist = '0; m_bits = 0; m_valid = 0; m_lost = 0;
      m_mcnt = 0; m_mcnt2 = 0; m_pok = 0;
    end else begin
      hit = 1'b0;
      if (dv) begin
        m_hist = {m_hist[2:0], d};
        m_bits++;
        hit = (m_bits >= 4) && (m_hist == 4'b1011);
      end
      if (hit) begin
        if (m_valid && !rdy) m_lost = 1'b1;
        m_valid = 1'b1;
        m_pok   = ~^m_hist;
        if (m_mcnt < 255) m_mcnt++;
        if (m_mcnt2 < 3) m_mcnt2++;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    e.shreg  = m_hist;
    e.filled = (m_bits >= 4);
    e.valid  = m_valid;
    e.lost   = m_lost;
    e.mcnt   = 8'(m_mcnt);
    e.mcnt2  = 2'(m_mcnt2);
    e.pok    = m_pok;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("shreg",     32'(shreg),       32'(e.shreg));
      check("filled",    32'(filled),      32'(e.filled));
      check("evt_valid", 32'(evt_valid),   32'(e.valid));
      check("lost",      32'(lost),        32'(e.lost));
      check("match_cnt", 32'(match_cnt),   32'(e.mcnt));
      check("sat_cnt",   32'(match_cnt_s), 32'(e.mcnt2));
`ifdef Q5_PARITY_EN
      check("parity",    32'(parity),      32'(^e.shreg));
      check("parity_ok", 32'(parity_ok),   32'(e.pok));
`endif
    end
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);

    // basic match, then event accepted next cycle
    feed(32'b1011, 4, 1'b1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // overlap with stalled consumer
    step(0, 0, 0, 1);
    feed(32'b1011011, 7, 1'b0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // din_valid gaps
    step(0, 0, 0, 1);
    feed(32'b10, 2, 1'b0);
    repeat (3) step(0, 1, 0, 0);
    feed(32'b11, 2, 1'b0);

    // saturation of the 2-bit counter: 1011 five times overlapping
    step(0, 0, 0, 1);
    feed(32'b1011011011011011, 16, 1'b1);

    // reset mid-operation
    step(0, 0, 0, 1);
    feed(32'b1011011, 7, 1'b0);
    feed(32'b101, 3, 1'b0);
    step(0, 0, 0, 1);
    feed(32'b1, 1, 1'b0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
